chip8_framebuffer: RTL and testbench

CHIP8_FRAMEBUFFER -- requirements
Module: chip8_framebuffer

---
 rtl/chip8_framebuffer_if.sv | 22 ++
 rtl/chip8_framebuffer.sv | 179 +++++++++++++++++
 tb/tb_chip8_framebuffer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/chip8_framebuffer_if.sv
// Command channel of the CHIP-8 framebuffer: request/ready handshake,
// DRAW parameters, and the completion/collision result.
interface chip8_framebuffer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [5:0] draw_x;
  logic [4:0] draw_y;
  logic [7:0] draw_row;
  logic       done;
  logic       collision;

  modport master (
    output cmd_valid, cmd_op, draw_x, draw_y, draw_row,
    input  cmd_ready, done, collision
  );

  modport slave (
    input  cmd_valid, cmd_op, draw_x, draw_y, draw_row,
    output cmd_ready, done, collision
  );
endinterface

// File: rtl/chip8_framebuffer.sv
// CHIP-8 monochrome framebuffer: one-bit pixel store with a free-running
// display read port and a command engine for sprite-row DRAW (XOR with
// collision detect) and full-screen CLEAR.
//
// state   | meaning
// --------+------------------------------------------------------------
// INIT    | post-reset sweep, zeroes rows 0..31 one per cycle
// IDLE    | cmd_ready high, waiting for a command
// D_READ  | fetch row draw_y into the working register
// D_WRITE | XOR sprite into working row, write back, compute collision
// CLEAR   | zero rows 0..31 one per cycle
// DONE    | one-cycle done pulse, collision already updated
module chip8_framebuffer #(
  parameter int FB_WIDTH  = 64,
  parameter int FB_HEIGHT = 32
) (
  input  logic                clk50,
  input  logic                reset,
  input  logic [10:0]         fb_request_addr,
  output logic                fb_pixel_data,
  chip8_framebuffer_if.slave  cmd
);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    D_READ,
    D_WRITE,
    CLEAR,
    DONE
  } state_t;

  localparam logic [4:0] ROW_LAST = 5'(FB_HEIGHT - 1);

  state_t               state;
  state_t               state_nxt;

  logic [FB_WIDTH-1:0]  fb_mem [FB_HEIGHT];

  logic [4:0]           row_cnt;
  logic                 row_clr;
  logic                 row_inc;
  logic                 accept;

  logic [5:0]           lat_x;
  logic [4:0]           lat_y;
  logic [7:0]           lat_row;

  logic [FB_WIDTH-1:0]  work_row;
  logic [FB_WIDTH-1:0]  sprite_mask;
  logic                 hit;
  logic                 collision_q;

  logic                 mem_we;
  logic [4:0]           mem_waddr;
  logic [FB_WIDTH-1:0]  mem_wdata;

  // State register; reset always restarts the INIT sweep.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and the single pixel-array write port selection.
  always_comb begin
    state_nxt = state;
    row_clr   = 1'b0;
    row_inc   = 1'b0;
    accept    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = row_cnt;
    mem_wdata = '0;
    case (state)
      INIT: begin
        mem_we  = 1'b1;
        row_inc = 1'b1;
        if (row_cnt == ROW_LAST) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (cmd.cmd_valid) begin
          accept    = 1'b1;
          row_clr   = 1'b1;
          state_nxt = cmd.cmd_op ? CLEAR : D_READ;
        end
      end
      D_READ: begin
        state_nxt = D_WRITE;
      end
      D_WRITE: begin
        mem_we    = 1'b1;
        mem_waddr = lat_y;
        mem_wdata = work_row ^ sprite_mask;
        state_nxt = DONE;
      end
      CLEAR: begin
        mem_we  = 1'b1;
        row_inc = 1'b1;
        if (row_cnt == ROW_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  // Spread the sprite byte across the row; columns wrap through the 6-bit add.
  always_comb begin
    sprite_mask = '0;
    for (int i = 0; i < 8; i++) begin
      sprite_mask[lat_x + 6'(i)] = lat_row[7 - i];
    end
  end

  assign hit = |(work_row & sprite_mask);

  // Row counter, command latches, working row and the held collision flag.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      row_cnt     <= '0;
      lat_x       <= '0;
      lat_y       <= '0;
      lat_row     <= '0;
      work_row    <= '0;
      collision_q <= 1'b0;
    end else begin
      if (row_clr) begin
        row_cnt <= '0;
      end else if (row_inc) begin
        row_cnt <= row_cnt + 5'd1;
      end
      if (accept) begin
        lat_x   <= cmd.draw_x;
        lat_y   <= cmd.draw_y;
        lat_row <= cmd.draw_row;
      end
      if (state == D_READ) begin
        work_row <= fb_mem[lat_y];
      end
      // Collision changes only on the edge entering DONE, so it is valid
      // together with the done pulse and held until the next one.
      if (state == D_WRITE) begin
        collision_q <= hit;
      end else if ((state == CLEAR) && (row_cnt == ROW_LAST)) begin
        collision_q <= 1'b0;
      end
    end
  end

  // Pixel array write; contents survive reset and are cleared by INIT.
  always_ff @(posedge clk50) begin
    if (mem_we) begin
      fb_mem[mem_waddr] <= mem_wdata;
    end
  end

  // Display read port: always active, sees the pre-write row on a collision.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      fb_pixel_data <= 1'b0;
    end else begin
      fb_pixel_data <= fb_mem[fb_request_addr[10:6]][fb_request_addr[5:0]];
    end
  end

  assign cmd.cmd_ready = (state == IDLE);
  assign cmd.done      = (state == DONE);
  assign cmd.collision = collision_q;

endmodule

// File: tb/tb_chip8_framebuffer.sv
// Self-checking bench for chip8_framebuffer: table of DRAW commands with
// expected latency/collision, a pixel model with a read scoreboard, and
// hand sequences for INIT, CLEAR with held request, and reset mid-DRAW.
module tb_chip8_framebuffer;

  logic        clk50 = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] fb_request_addr = '0;
  logic        fb_pixel_data;

  chip8_framebuffer_if bus ();

  chip8_framebuffer dut (
    .clk50           (clk50),
    .reset           (reset),
    .fb_request_addr (fb_request_addr),
    .fb_pixel_data   (fb_pixel_data),
    .cmd             (bus)
  );

  always #10 clk50 = ~clk50;

  typedef struct {
    logic       op;
    logic [5:0] x;
    logic [4:0] y;
    logic [7:0] row;
    int         exp_lat;
    logic       exp_coll;
  } vec_t;

  typedef struct {
    int   addr;
    logic exp;
  } rd_t;

  logic [63:0] model [32];
  rd_t         sb [$];
  vec_t        vecs [7];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic step();
    @(posedge clk50);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int r = 0; r < 32; r++) model[r] = '0;
  endfunction

  function automatic void model_draw(input int x, input int y, input logic [7:0] r);
    for (int i = 0; i < 8; i++) begin
      if (r[7 - i]) model[y][(x + i) % 64] = ~model[y][(x + i) % 64];
    end
  endfunction

  // Pipelined read sweep: push expected at address drive, pop one cycle later.
  task automatic scan(input int lo, input int hi);
    rd_t e;
    for (int a = lo; a <= hi + 1; a++) begin
      if (a > lo) begin
        if (sb.size() == 0) begin
          check("sb_empty", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check($sformatf("pix[%0d]", e.addr), 64'(fb_pixel_data), 64'(e.exp));
        end
      end
      if (a <= hi) begin
        fb_request_addr = 11'(a);
        sb.push_back('{a, model[a / 64][a % 64]});
        step();
      end
    end
  endtask

  task automatic do_reset_init();
    int cnt = 0;
    bit done_seen = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_ready", 64'(bus.cmd_ready), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_collision", 64'(bus.collision), 64'd0);
    check("rst_pixel", 64'(fb_pixel_data), 64'd0);
    step();
    step();
    reset = 1'b0;
    while (!bus.cmd_ready && cnt < 100) begin
      if (bus.done) done_seen = 1'b1;
      step();
      cnt++;
    end
    check("init_cycles", 64'(cnt), 64'd32);
    check("init_no_done", 64'(done_seen), 64'd0);
    model_clear();
  endtask

  task automatic run_cmd(input vec_t v, input bit hold_valid, output int lat, output logic coll);
    int n = 0;
    int ready_seen = 0;
    bus.cmd_op    = v.op;
    bus.draw_x    = v.x;
    bus.draw_y    = v.y;
    bus.draw_row  = v.row;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 200) begin
      step();
      n++;
    end
    check("ready_before_cmd", 64'(bus.cmd_ready), 64'd1);
    step();
    if (!hold_valid) bus.cmd_valid = 1'b0;
    bus.draw_x   = ~v.x;
    bus.draw_y   = ~v.y;
    bus.draw_row = ~v.row;
    lat = 1;
    while (!bus.done && lat < 100) begin
      if (bus.cmd_ready) ready_seen++;
      step();
      lat++;
    end
    coll = bus.collision;
    bus.cmd_valid = 1'b0;
    check("busy_ready", 64'(ready_seen), 64'd0);
    step();
    check("done_one_cycle", 64'(bus.done), 64'd0);
    check("ready_after_done", 64'(bus.cmd_ready), 64'd1);
  endtask

  initial begin
    int   lat;
    logic coll;
    int   lo, hi;
    int   n;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.draw_x    = '0;
    bus.draw_y    = '0;
    bus.draw_row  = '0;

    vecs[0] = '{1'b0, 6'd0,  5'd0,  8'hFF, 3, 1'b0};
    vecs[1] = '{1'b0, 6'd0,  5'd0,  8'hFF, 3, 1'b1};
    vecs[2] = '{1'b0, 6'd60, 5'd5,  8'hFF, 3, 1'b0};
    vecs[3] = '{1'b0, 6'd62, 5'd5,  8'h81, 3, 1'b1};
    vecs[4] = '{1'b0, 6'd10, 5'd31, 8'hA5, 3, 1'b0};
    vecs[5] = '{1'b0, 6'd20, 5'd31, 8'h00, 3, 1'b0};
    vecs[6] = '{1'b0, 6'd8,  5'd31, 8'h0F, 3, 1'b1};

    #5;
    do_reset_init();
    scan(0, 2047);

    for (int k = 0; k < 7; k++) begin
      run_cmd(vecs[k], 1'b0, lat, coll);
      model_draw(int'(vecs[k].x), int'(vecs[k].y), vecs[k].row);
      check($sformatf("v%0d_latency", k), 64'(lat), 64'(vecs[k].exp_lat));
      check($sformatf("v%0d_collision", k), 64'(coll), 64'(vecs[k].exp_coll));
      lo = (vecs[k].y == 0) ? 0 : int'(vecs[k].y) - 1;
      hi = (vecs[k].y == 31) ? 31 : int'(vecs[k].y) + 1;
      scan(lo * 64, hi * 64 + 63);
    end

    run_cmd('{1'b1, 6'd0, 5'd0, 8'h00, 33, 1'b0}, 1'b1, lat, coll);
    model_clear();
    check("clear_latency", 64'(lat), 64'd33);
    check("clear_collision", 64'(coll), 64'd0);
    scan(0, 2047);

    run_cmd('{1'b0, 6'd0, 5'd2, 8'hFF, 3, 1'b0}, 1'b0, lat, coll);
    model_draw(0, 2, 8'hFF);
    check("pre_rst_coll_a", 64'(coll), 64'd0);
    run_cmd('{1'b0, 6'd4, 5'd2, 8'hF0, 3, 1'b1}, 1'b0, lat, coll);
    model_draw(4, 2, 8'hF0);
    check("pre_rst_coll_b", 64'(coll), 64'd1);
    scan(128, 191);
    fb_request_addr = 11'd128;
    step();
    step();
    check("pre_rst_pixel", 64'(fb_pixel_data), 64'(model[2][0]));

    bus.cmd_op    = 1'b0;
    bus.draw_x    = 6'd0;
    bus.draw_y    = 5'd1;
    bus.draw_row  = 8'hFF;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      step();
      n++;
    end
    check("mid_ready", 64'(bus.cmd_ready), 64'd1);
    step();
    bus.cmd_valid = 1'b0;
    step();
    do_reset_init();
    scan(0, 2047);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
